isdu_v2: RTL and testbench

ISDU_V2 -- requirements
Module: isdu_v2

---
 rtl/isdu_pkg.sv | 64 ++++++
 rtl/mem_wait_ctr.sv | 33 +++
 rtl/isdu_v2.sv | 253 +++++++++++++++++++++++++
 tb/tb_isdu_v2.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/isdu_pkg.sv
// ISDU shared definitions: state encoding, opcodes,
// mux encodings and a memory-state helper.
package isdu_pkg;

  typedef enum logic [4:0] {
    S_HALTED  = 5'd0,
    S_F1      = 5'd1,
    S_F_RD    = 5'd2,
    S_F3      = 5'd3,
    S_DEC     = 5'd4,
    S_ALU     = 5'd5,
    S_BR      = 5'd6,
    S_JMP     = 5'd7,
    S_JSR     = 5'd8,
    S_LEA     = 5'd9,
    S_ADR     = 5'd10,
    S_IND_RD  = 5'd11,
    S_IND_LD  = 5'd12,
    S_D_RD    = 5'd13,
    S_D_LD    = 5'd14,
    S_WR_PREP = 5'd15,
    S_D_WR    = 5'd16,
    S_PAUSE1  = 5'd17,
    S_PAUSE2  = 5'd18
  } state_t;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_JSR = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_PSE = 4'b1101;
  localparam logic [3:0] OP_LEA = 4'b1110;

  localparam logic [1:0] PC_INC = 2'b00;
  localparam logic [1:0] PC_ADD = 2'b01;
  localparam logic [1:0] PC_BUS = 2'b10;

  localparam logic [1:0] A2_ZERO  = 2'b00;
  localparam logic [1:0] A2_OFF6  = 2'b01;
  localparam logic [1:0] A2_OFF9  = 2'b10;
  localparam logic [1:0] A2_OFF11 = 2'b11;

  localparam logic A1_PC  = 1'b0;
  localparam logic A1_SR1 = 1'b1;

  localparam logic [1:0] ALUK_ADD  = 2'b00;
  localparam logic [1:0] ALUK_AND  = 2'b01;
  localparam logic [1:0] ALUK_NOT  = 2'b10;
  localparam logic [1:0] ALUK_PASS = 2'b11;

  function automatic logic is_mem(input state_t s);
    return (s == S_F_RD) || (s == S_IND_RD) ||
           (s == S_D_RD) || (s == S_D_WR);
  endfunction

endpackage

// File: rtl/mem_wait_ctr.sv
// Memory wait counter shared by all memory-access states.
// load: preset to MEM_WAIT-1; active: in a memory state; done: access completes.
import isdu_pkg::*;

module mem_wait_ctr #(
  parameter int MEM_WAIT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic active,
  input  logic rdy,
  output logic done
);

  localparam logic [3:0] INIT = 4'(MEM_WAIT - 1);

  logic [3:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= INIT;
    end else if (active && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Saturated counter plus memory ready closes the access.
  assign done = active && (cnt == 4'd0) && rdy;

endmodule

// File: rtl/isdu_v2.sv
// ISDU control sequencer: fetch/decode/execute FSM driving datapath loads,
// bus gates, mux selects and active-low memory strobes.
import isdu_pkg::*;

module isdu_v2 #(
  parameter int MEM_WAIT = 2,
  parameter int EXT_OPS  = 1
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Run,
  input  logic        Continue,
  input  logic [15:0] IR,
  input  logic [2:0]  NZP,
  input  logic        Mem_Rdy,
  output logic        LD_MAR,
  output logic        LD_MDR,
  output logic        LD_IR,
  output logic        LD_CC,
  output logic        LD_REG,
  output logic        LD_PC,
  output logic        GatePC,
  output logic        GateMDR,
  output logic        GateALU,
  output logic        GateMARMUX,
  output logic [1:0]  PCMUX,
  output logic [1:0]  ADDR2MUX,
  output logic [1:0]  ALUK,
  output logic        ADDR1MUX,
  output logic        SR1MUX,
  output logic        SR2MUX,
  output logic        DRMUX,
  output logic        MDRMUX,
  output logic        Mem_OE,
  output logic        Mem_WE,
  output logic        Mem_CE,
  output logic        Mem_UB,
  output logic        Mem_LB,
  output logic [4:0]  State_out
);

  localparam logic EXT = (EXT_OPS != 0);

  state_t state, state_n;
  logic   mem_done, ctr_load;
  logic [3:0] op;
  logic is_alu, is_br, is_jmp, is_jsr;
  logic is_lea, is_ls, is_pse;
  logic is_ind, is_load, is_base;
  logic unused_ir;

  assign op        = IR[15:12];
  assign unused_ir = ^{IR[8:6], IR[4:0]};

  assign is_alu  = (op == OP_ADD) || (op == OP_AND) ||
                   (op == OP_NOT);
  assign is_br   = (op == OP_BR);
  assign is_jmp  = (op == OP_JMP);
  assign is_jsr  = EXT && (op == OP_JSR);
  assign is_lea  = EXT && (op == OP_LEA);
  assign is_ind  = EXT && ((op == OP_LDI) || (op == OP_STI));
  assign is_ls   = is_ind || (op == OP_LD) || (op == OP_LDR) ||
                   (op == OP_ST) || (op == OP_STR);
  assign is_pse  = (op == OP_PSE);
  assign is_load = (op == OP_LD) || (op == OP_LDR);
  assign is_base = (op == OP_LDR) || (op == OP_STR);

  assign Mem_CE    = 1'b0;
  assign Mem_UB    = 1'b0;
  assign Mem_LB    = 1'b0;
  assign State_out = state;

  // Preset only on entry so a stalled access keeps its count.
  assign ctr_load = is_mem(state_n) && (state_n != state);

  mem_wait_ctr #(
    .MEM_WAIT(MEM_WAIT)
  ) u_wait (
    .clk   (Clk),
    .rst_n (Reset_n),
    .load  (ctr_load),
    .active(is_mem(state)),
    .rdy   (Mem_Rdy),
    .done  (mem_done)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= S_HALTED;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n    = state;
    LD_MAR     = 1'b0;
    LD_MDR     = 1'b0;
    LD_IR      = 1'b0;
    LD_CC      = 1'b0;
    LD_REG     = 1'b0;
    LD_PC      = 1'b0;
    GatePC     = 1'b0;
    GateMDR    = 1'b0;
    GateALU    = 1'b0;
    GateMARMUX = 1'b0;
    PCMUX      = PC_INC;
    ADDR2MUX   = A2_ZERO;
    ALUK       = ALUK_ADD;
    ADDR1MUX   = A1_PC;
    SR1MUX     = 1'b0;
    SR2MUX     = 1'b0;
    DRMUX      = 1'b0;
    MDRMUX     = 1'b0;
    Mem_OE     = 1'b1;
    Mem_WE     = 1'b1;
    unique case (state)
      S_HALTED: begin
        if (Run) state_n = S_F1;
      end
      S_F1: begin
        GatePC  = 1'b1;
        LD_MAR  = 1'b1;
        LD_PC   = 1'b1;
        state_n = S_F_RD;
      end
      S_F_RD, S_IND_RD, S_D_RD: begin
        Mem_OE = 1'b0;
        if (mem_done) begin
          LD_MDR = 1'b1;
          unique case (state)
            S_F_RD:   state_n = S_F3;
            S_IND_RD: state_n = S_IND_LD;
            default:  state_n = S_D_LD;
          endcase
        end
      end
      S_F3: begin
        GateMDR = 1'b1;
        LD_IR   = 1'b1;
        state_n = S_DEC;
      end
      S_DEC: begin
        unique case (1'b1)
          is_alu:  state_n = S_ALU;
          is_br:   state_n = ((NZP & IR[11:9]) != 3'b000)
                             ? S_BR : S_F1;
          is_jmp:  state_n = S_JMP;
          is_jsr:  state_n = S_JSR;
          is_lea:  state_n = S_LEA;
          is_ls:   state_n = S_ADR;
          is_pse:  state_n = S_PAUSE1;
          default: state_n = S_F1;
        endcase
      end
      S_ALU: begin
        unique case (op)
          OP_AND:  ALUK = ALUK_AND;
          OP_NOT:  ALUK = ALUK_NOT;
          default: ALUK = ALUK_ADD;
        endcase
        SR2MUX  = IR[5];
        GateALU = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
        state_n = S_F1;
      end
      S_BR: begin
        ADDR1MUX = A1_PC;
        ADDR2MUX = A2_OFF9;
        PCMUX    = PC_ADD;
        LD_PC    = 1'b1;
        state_n  = S_F1;
      end
      S_JMP: begin
        PCMUX   = PC_BUS;
        GateALU = 1'b1;
        ALUK    = ALUK_PASS;
        LD_PC   = 1'b1;
        state_n = S_F1;
      end
      S_JSR: begin
        // Old PC goes to R7 while PC takes the target.
        GatePC = 1'b1;
        DRMUX  = 1'b1;
        LD_REG = 1'b1;
        PCMUX  = PC_ADD;
        LD_PC  = 1'b1;
        if (IR[11]) begin
          ADDR1MUX = A1_PC;
          ADDR2MUX = A2_OFF11;
        end else begin
          ADDR1MUX = A1_SR1;
          ADDR2MUX = A2_ZERO;
        end
        state_n = S_F1;
      end
      S_LEA: begin
        ADDR2MUX   = A2_OFF9;
        GateMARMUX = 1'b1;
        LD_REG     = 1'b1;
        LD_CC      = 1'b1;
        state_n    = S_F1;
      end
      S_ADR: begin
        GateMARMUX = 1'b1;
        LD_MAR     = 1'b1;
        if (is_base) begin
          ADDR1MUX = A1_SR1;
          ADDR2MUX = A2_OFF6;
        end else begin
          ADDR1MUX = A1_PC;
          ADDR2MUX = A2_OFF9;
        end
        if (is_ind)       state_n = S_IND_RD;
        else if (is_load) state_n = S_D_RD;
        else              state_n = S_WR_PREP;
      end
      S_IND_LD: begin
        GateMDR = 1'b1;
        LD_MAR  = 1'b1;
        state_n = (op == OP_LDI) ? S_D_RD : S_WR_PREP;
      end
      S_D_LD: begin
        GateMDR = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
        state_n = S_F1;
      end
      S_WR_PREP: begin
        SR1MUX  = 1'b1;
        ALUK    = ALUK_PASS;
        GateALU = 1'b1;
        MDRMUX  = 1'b1;
        LD_MDR  = 1'b1;
        state_n = S_D_WR;
      end
      S_D_WR: begin
        Mem_WE = 1'b0;
        if (mem_done) state_n = S_F1;
      end
      S_PAUSE1: begin
        if (Continue) state_n = S_PAUSE2;
      end
      S_PAUSE2: begin
        // Continue must drop before the next fetch.
        if (!Continue) state_n = S_F1;
      end
      default: state_n = S_HALTED;
    endcase
  end

endmodule

// File: tb/tb_isdu_v2.sv
// Directed table-driven bench for isdu_v2 plus
// hand sequences for memory waits, pause, and reset.
module tb_isdu_v2;
  import isdu_pkg::*;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  logic Run = 1'b0;
  logic Continue = 1'b0;
  logic Mem_Rdy = 1'b1;
  logic rdy3 = 1'b1;
  logic [15:0] IR = 16'h0;
  logic [2:0] NZP = 3'b0;

  logic LD_MAR, LD_MDR, LD_IR, LD_CC, LD_REG, LD_PC;
  logic GatePC, GateMDR, GateALU, GateMARMUX;
  logic [1:0] PCMUX, ADDR2MUX, ALUK;
  logic ADDR1MUX, SR1MUX, SR2MUX, DRMUX, MDRMUX;
  logic Mem_OE, Mem_WE, Mem_CE, Mem_UB, Mem_LB;
  logic [4:0] State_out;

  logic d3_ld_mar, d3_ld_mdr, d3_ld_ir, d3_ld_cc, d3_ld_reg, d3_ld_pc;
  logic d3_gpc, d3_gmdr, d3_galu, d3_gmar;
  logic [1:0] d3_pcmux, d3_a2, d3_aluk;
  logic d3_a1, d3_sr1, d3_sr2, d3_dr, d3_mdrmux;
  logic d3_oe, d3_we, d3_ce, d3_ub, d3_lb;
  logic [4:0] d3_state;

  always #5 Clk = ~Clk;

  isdu_v2 #(.MEM_WAIT(2), .EXT_OPS(1)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Run(Run), .Continue(Continue),
    .IR(IR), .NZP(NZP), .Mem_Rdy(Mem_Rdy),
    .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_CC(LD_CC),
    .LD_REG(LD_REG), .LD_PC(LD_PC),
    .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU),
    .GateMARMUX(GateMARMUX),
    .PCMUX(PCMUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK),
    .ADDR1MUX(ADDR1MUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX),
    .DRMUX(DRMUX), .MDRMUX(MDRMUX),
    .Mem_OE(Mem_OE), .Mem_WE(Mem_WE), .Mem_CE(Mem_CE),
    .Mem_UB(Mem_UB), .Mem_LB(Mem_LB), .State_out(State_out)
  );

  isdu_v2 #(.MEM_WAIT(3), .EXT_OPS(1)) dut3 (
    .Clk(Clk), .Reset_n(Reset_n), .Run(Run), .Continue(Continue),
    .IR(IR), .NZP(NZP), .Mem_Rdy(rdy3),
    .LD_MAR(d3_ld_mar), .LD_MDR(d3_ld_mdr), .LD_IR(d3_ld_ir),
    .LD_CC(d3_ld_cc), .LD_REG(d3_ld_reg), .LD_PC(d3_ld_pc),
    .GatePC(d3_gpc), .GateMDR(d3_gmdr), .GateALU(d3_galu),
    .GateMARMUX(d3_gmar),
    .PCMUX(d3_pcmux), .ADDR2MUX(d3_a2), .ALUK(d3_aluk),
    .ADDR1MUX(d3_a1), .SR1MUX(d3_sr1), .SR2MUX(d3_sr2),
    .DRMUX(d3_dr), .MDRMUX(d3_mdrmux),
    .Mem_OE(d3_oe), .Mem_WE(d3_we), .Mem_CE(d3_ce),
    .Mem_UB(d3_ub), .Mem_LB(d3_lb), .State_out(d3_state)
  );

  typedef struct {
    logic [15:0] ir;
    logic [2:0]  nzp;
    state_t      st;
    logic [3:0]  gate;
    logic [4:0]  ld;
    logic [1:0]  pcmux;
    logic [1:0]  a2;
    logic [1:0]  aluk;
    logic        a1;
    logic        sr2;
    logic        dr;
  } vec_t;

  vec_t vecs[16];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  // {state, gates PC/MDR/ALU/MAR, loads MAR/MDR/REG/CC/PC, muxes}
  function automatic logic [22:0] ctl();
    return {State_out, GatePC, GateMDR, GateALU, GateMARMUX,
            LD_MAR, LD_MDR, LD_REG, LD_CC, LD_PC,
            PCMUX, ADDR2MUX, ALUK, ADDR1MUX, SR2MUX, DRMUX};
  endfunction

  function automatic logic [9:0] enables();
    return {LD_MAR, LD_MDR, LD_IR, LD_CC, LD_REG, LD_PC,
            GatePC, GateMDR, GateALU, GateMARMUX};
  endfunction

  task automatic do_reset;
    Reset_n = 1'b0;
    Run = 1'b0;
    Continue = 1'b0;
    repeat (2) tick;
    Reset_n = 1'b1;
    tick;
  endtask

  task automatic run_to_f1(input string nm);
    int n;
    n = 0;
    while (State_out != 5'(S_F1) && n < 20) begin
      tick;
      n++;
    end
    chk(nm, State_out, S_F1);
  endtask

  initial begin
    state_t sq[8];
    logic   we_exp[8];
    logic   oe_exp[5];
    int     bad;

    // ir, nzp, state, gate, ld, pcmux, a2, aluk, a1, sr2, dr
    vecs[0]  = '{16'h1042, 3'b000, S_ALU, 4'b0010, 5'b00110,
                 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{16'h5265, 3'b000, S_ALU, 4'b0010, 5'b00110,
                 2'b00, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{16'h927F, 3'b000, S_ALU, 4'b0010, 5'b00110,
                 2'b00, 2'b00, 2'b10, 1'b0, 1'b1, 1'b0};
    // IR[11:9]=101 (n,p)
    vecs[3]  = '{16'h0A05, 3'b100, S_BR, 4'b0000, 5'b00001,
                 2'b01, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{16'h0A05, 3'b010, S_F1, 4'b1000, 5'b10001,
                 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{16'h0405, 3'b010, S_BR, 4'b0000, 5'b00001,
                 2'b01, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{16'h0E00, 3'b000, S_F1, 4'b1000, 5'b10001,
                 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{16'hC1C0, 3'b000, S_JMP, 4'b0010, 5'b00001,
                 2'b10, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{16'h4805, 3'b000, S_JSR, 4'b1000, 5'b00101,
                 2'b01, 2'b11, 2'b00, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{16'h4080, 3'b000, S_JSR, 4'b1000, 5'b00101,
                 2'b01, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{16'hE005, 3'b000, S_LEA, 4'b0001, 5'b00110,
                 2'b00, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{16'h2005, 3'b000, S_ADR, 4'b0001, 5'b10000,
                 2'b00, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{16'h6045, 3'b000, S_ADR, 4'b0001, 5'b10000,
                 2'b00, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{16'hB1C0, 3'b000, S_ADR, 4'b0001, 5'b10000,
                 2'b00, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{16'h8000, 3'b000, S_F1, 4'b1000, 5'b10001,
                 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{16'hF000, 3'b000, S_F1, 4'b1000, 5'b10001,
                 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};

    // Reset state
    Reset_n = 1'b0;
    #3;
    chk("rst_state", State_out, S_HALTED);
    chk("rst_en", enables(), 10'h0);
    chk("rst_strobe", {Mem_OE, Mem_WE}, 2'b11);
    chk("tied", {Mem_CE, Mem_UB, Mem_LB}, 3'b000);
    repeat (2) tick;
    Reset_n = 1'b1;
    tick;
    chk("halt_norun", State_out, S_HALTED);

    // Fetch with MEM_WAIT=2
    Run = 1'b1;
    IR = 16'h0000;
    NZP = 3'b000;
    tick;
    Run = 1'b0;
    chk("f1", {State_out, GatePC, LD_MAR, LD_PC, PCMUX},
        {5'(S_F1), 3'b111, 2'b00});
    tick;
    chk("frd1", {State_out, Mem_OE, LD_MDR}, {5'(S_F_RD), 2'b00});
    tick;
    chk("frd2", {State_out, Mem_OE, LD_MDR, MDRMUX},
        {5'(S_F_RD), 3'b010});
    tick;
    chk("f3", {State_out, GateMDR, LD_IR, Mem_OE},
        {5'(S_F3), 3'b111});
    tick;
    chk("dec", {State_out, enables()}, {5'(S_DEC), 10'h0});
    tick;
    chk("br_nop", State_out, S_F1);

    // Decode table
    for (int i = 0; i < 16; i++) begin
      IR = vecs[i].ir;
      NZP = vecs[i].nzp;
      repeat (4) tick;
      chk($sformatf("v%0d_dec", i), State_out, S_DEC);
      tick;
      chk($sformatf("v%0d_ctl", i), ctl(),
          {5'(vecs[i].st), vecs[i].gate, vecs[i].ld,
           vecs[i].pcmux, vecs[i].a2, vecs[i].aluk,
           vecs[i].a1, vecs[i].sr2, vecs[i].dr});
      run_to_f1($sformatf("v%0d_ret", i));
    end

    // STI: indirect store walk
    sq = '{S_ADR, S_IND_RD, S_IND_RD, S_IND_LD,
           S_WR_PREP, S_D_WR, S_D_WR, S_F1};
    we_exp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    IR = 16'hB1C0;
    repeat (4) tick;
    for (int i = 0; i < 8; i++) begin
      tick;
      chk($sformatf("sti%0d", i), {State_out, Mem_WE},
          {5'(sq[i]), we_exp[i]});
      if (i == 4)
        chk("wr_prep", {LD_MDR, MDRMUX, SR1MUX, GateALU, ALUK},
            6'b111111);
    end

    // LD: direct load walk
    sq[0:4] = '{S_ADR, S_D_RD, S_D_RD, S_D_LD, S_F1};
    oe_exp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    IR = 16'h2005;
    repeat (4) tick;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk($sformatf("ld%0d", i), {State_out, Mem_OE},
          {5'(sq[i]), oe_exp[i]});
      if (i == 3)
        chk("d_ld", {GateMDR, LD_REG, LD_CC, LD_MDR}, 4'b1110);
    end

    // Pause with Continue held
    IR = 16'hD000;
    repeat (4) tick;
    tick;
    chk("pause1", State_out, S_PAUSE1);
    repeat (3) tick;
    chk("pause1_hold", State_out, S_PAUSE1);
    Continue = 1'b1;
    bad = 0;
    repeat (20) begin
      tick;
      if (State_out != 5'(S_PAUSE2)) bad++;
    end
    chk("pause2_hold", bad, 0);
    Continue = 1'b0;
    tick;
    chk("pause_rel", State_out, S_F1);
    repeat (4) tick;
    chk("pause_dec", State_out, S_DEC);
    tick;
    chk("pause_again", State_out, S_PAUSE1);

    // MEM_WAIT=3 with two not-ready cycles at zero
    do_reset;
    rdy3 = 1'b0;
    Run = 1'b1;
    IR = 16'h0000;
    tick;
    Run = 1'b0;
    chk("w3_f1", d3_state, S_F1);
    for (int c = 1; c <= 5; c++) begin
      tick;
      if (c == 5) begin
        rdy3 = 1'b1;
        #1;
      end
      chk($sformatf("w3_rd%0d", c), {d3_state, d3_oe, d3_ld_mdr},
          {5'(S_F_RD), 1'b0, (c == 5)});
    end
    tick;
    chk("w3_f3", {d3_state, d3_oe}, {5'(S_F3), 1'b1});

    // Asynchronous reset in the middle of a write
    do_reset;
    Run = 1'b1;
    IR = 16'hB1C0;
    tick;
    Run = 1'b0;
    repeat (10) tick;
    chk("wr_pre_rst", {State_out, Mem_WE}, {5'(S_D_WR), 1'b0});
    #2;
    Reset_n = 1'b0;
    #1;
    chk("wr_rst", {State_out, Mem_WE, Mem_OE, enables()},
        {5'(S_HALTED), 2'b11, 10'h0});
    Reset_n = 1'b1;
    Run = 1'b1;
    #1;
    chk("rel_wait", State_out, S_HALTED);
    tick;
    chk("rel_f1", State_out, S_F1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
